// File: rtl/param_inputbuffers.sv
// Bank of NUM_PORTS independent show-ahead input FIFOs; head visible one cycle after push, no bypass.
// Backpressure: en_o drops when a port is full and further pushes are dropped; optional INBUF_STATS_EN adds drop counters.
module param_inputbuffers #(
  parameter int NUM_PORTS  = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int AF_THRESH  = 1,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_i,
  input  logic [NUM_PORTS-1:0]            valid_i,
  input  logic [NUM_PORTS-1:0]            pop_req_i,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] data_o,
  output logic [NUM_PORTS-1:0]            valid_o,
  output logic [NUM_PORTS-1:0]            en_o,
  output logic [NUM_PORTS-1:0]            almost_full_o,
  output logic [NUM_PORTS*CNT_W-1:0]      occupancy_o,
  output logic [NUM_PORTS-1:0]            overflow_o,
  output logic [NUM_PORTS-1:0]            underflow_o,
  output logic [NUM_PORTS*16-1:0]         drop_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_ovf;
    logic                  r_udf;
    logic                  w_vld;
    logic                  w_en;
    logic                  w_push;
    logic                  w_pop;
    logic [CNT_W-1:0]      w_free;

    assign w_vld  = (r_count != '0);
    assign w_en   = (r_count != DEPTH_C);
    assign w_free = DEPTH_C - r_count;
    assign w_push = valid_i[p] & w_en;
    assign w_pop  = pop_req_i[p] & w_vld;

    assign valid_o[p]                        = w_vld;
    assign en_o[p]                           = w_en;
    assign almost_full_o[p]                  = (w_free <= AF_C);
    assign occupancy_o[p*CNT_W +: CNT_W]     = r_count;
    assign overflow_o[p]                     = r_ovf;
    assign underflow_o[p]                    = r_udf;
    assign data_o[p*DATA_WIDTH +: DATA_WIDTH] = w_vld ? r_mem[r_rd_ptr] : '0;

    // Storage carries no reset; an entry is only observable once the count covers it.
    always_ff @(posedge clk) begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= data_i[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_ovf    <= 1'b0;
        r_udf    <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
        if (valid_i[p] & ~w_en)   r_ovf <= 1'b1;
        if (pop_req_i[p] & ~w_vld) r_udf <= 1'b1;
      end
    end

`ifdef INBUF_STATS_EN
    logic [15:0] r_drop;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_drop <= '0;
      end else if ((valid_i[p] & ~w_en) && (r_drop != 16'hFFFF)) begin
        r_drop <= r_drop + 16'd1;
      end
    end

    assign drop_cnt_o[p*16 +: 16] = r_drop;
`else
    assign drop_cnt_o[p*16 +: 16] = '0;
`endif
  end

endmodule

// File: tb/tb_param_inputbuffers.sv
// Directed bench for param_inputbuffers: queue-based per-port model checked every cycle plus literal spot checks.
module tb_param_inputbuffers;
  localparam int NP = 5;
  localparam int DW = 32;
  localparam int D  = 4;
  localparam int AF = 1;
  localparam int CW = $clog2(D + 1);
`ifdef INBUF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                 clk;
  logic                 rst;
  logic [NP*DW-1:0]     data_i;
  logic [NP-1:0]        valid_i;
  logic [NP-1:0]        pop_req_i;
  logic [NP*DW-1:0]     data_o;
  logic [NP-1:0]        valid_o;
  logic [NP-1:0]        en_o;
  logic [NP-1:0]        almost_full_o;
  logic [NP*CW-1:0]     occupancy_o;
  logic [NP-1:0]        overflow_o;
  logic [NP-1:0]        underflow_o;
  logic [NP*16-1:0]     drop_cnt_o;

  int tests  = 0;
  int failed = 0;

  param_inputbuffers #(
    .NUM_PORTS (NP),
    .DATA_WIDTH(DW),
    .DEPTH     (D),
    .AF_THRESH (AF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .pop_req_i    (pop_req_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .en_o         (en_o),
    .almost_full_o(almost_full_o),
    .occupancy_o  (occupancy_o),
    .overflow_o   (overflow_o),
    .underflow_o  (underflow_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: one queue per port plus sticky flags and drop counts.
  logic [DW-1:0] mq [NP][$];
  bit            movf  [NP];
  bit            mudf  [NP];
  int            mdrop [NP];
  bit            chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NP; p++) begin
        mq[p].delete();
        movf[p]  = 1'b0;
        mudf[p]  = 1'b0;
        mdrop[p] = 0;
      end
      chk_en = 1'b1;
    end else begin
      for (int p = 0; p < NP; p++) begin
        bit full, empty;
        full  = (mq[p].size() == D);
        empty = (mq[p].size() == 0);
        if (valid_i[p] && full) begin
          movf[p] = 1'b1;
          if (STATS && mdrop[p] < 65535) mdrop[p]++;
        end
        if (pop_req_i[p] && empty) mudf[p] = 1'b1;
        if (pop_req_i[p] && !empty) void'(mq[p].pop_front());
        if (valid_i[p] && !full) mq[p].push_back(data_i[p*DW +: DW]);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < NP; p++) begin
        int            n;
        logic [DW-1:0] e_dat;
        logic          e_vld, e_en, e_af, e_ovf, e_udf;
        logic [CW-1:0] e_occ;
        logic [15:0]   e_drop;
        n      = mq[p].size();
        e_vld  = (n != 0);
        e_en   = (n < D);
        e_af   = ((D - n) <= AF);
        e_occ  = CW'(n);
        e_dat  = (n != 0) ? mq[p][0] : '0;
        e_ovf  = movf[p];
        e_udf  = mudf[p];
        e_drop = 16'(mdrop[p]);
        tests++;
        if (valid_o[p] !== e_vld || en_o[p] !== e_en || almost_full_o[p] !== e_af ||
            occupancy_o[p*CW +: CW] !== e_occ || data_o[p*DW +: DW] !== e_dat ||
            overflow_o[p] !== e_ovf || underflow_o[p] !== e_udf ||
            drop_cnt_o[p*16 +: 16] !== e_drop) begin
          failed++;
          $display("FAIL model port%0d t=%0t: got vld=%b en=%b af=%b occ=%0d dat=%h ovf=%b udf=%b drop=%0d, want vld=%b en=%b af=%b occ=%0d dat=%h ovf=%b udf=%b drop=%0d",
                   p, $time, valid_o[p], en_o[p], almost_full_o[p], occupancy_o[p*CW +: CW],
                   data_o[p*DW +: DW], overflow_o[p], underflow_o[p], drop_cnt_o[p*16 +: 16],
                   e_vld, e_en, e_af, e_occ, e_dat, e_ovf, e_udf, e_drop);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_i   = '0;
    pop_req_i = '0;
    data_i    = '0;
  endtask

  function automatic logic [31:0] dat(input int p);
    return data_o[p*DW +: DW];
  endfunction

  function automatic logic [31:0] occ(input int p);
    return 32'(occupancy_o[p*CW +: CW]);
  endfunction

  initial begin
    rst = 1'b1;
    idle();
    valid_i = '1;
    for (int p = 0; p < NP; p++) data_i[p*DW +: DW] = 32'hDEAD_0000 + p;
    tick();
    tick();
    rst = 1'b0;
    idle();
    chk("reset_valid", 32'(valid_o), 32'h0);
    chk("reset_en", 32'(en_o), 32'h1F);
    chk("reset_occ", 32'(occupancy_o), 32'h0);
    chk("reset_ovf", 32'(overflow_o), 32'h0);
    tick();
    chk("reset_nostore", 32'(valid_o), 32'h0);

    // Fill and drain port 2.
    for (int i = 0; i < 4; i++) begin
      valid_i = 5'b00100;
      data_i[2*DW +: DW] = 32'hA0 + i;
      tick();
      if (i == 2) begin
        chk("fill_af_after3", 32'(almost_full_o[2]), 32'h1);
        chk("fill_en_after3", 32'(en_o[2]), 32'h1);
      end
    end
    idle();
    chk("fill_en_full", 32'(en_o[2]), 32'h0);
    chk("fill_occ4", occ(2), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", dat(2), 32'hA0 + i);
      pop_req_i = 5'b00100;
      tick();
    end
    idle();
    chk("drain_empty", 32'(valid_o[2]), 32'h0);

    // Overflow on port 0 with a simultaneous pop.
    for (int i = 0; i < 4; i++) begin
      valid_i = 5'b00001;
      data_i[0 +: DW] = 32'h10 + i;
      tick();
    end
    valid_i   = 5'b00001;
    pop_req_i = 5'b00001;
    data_i[0 +: DW] = 32'hFF;
    tick();
    idle();
    chk("ovf_flag", 32'(overflow_o[0]), 32'h1);
    chk("ovf_occ3", occ(0), 32'd3);
    chk("ovf_head", dat(0), 32'h11);
    chk("ovf_drop", 32'(drop_cnt_o[15:0]), STATS ? 32'd1 : 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("ovf_drain", dat(0), 32'h11 + i);
      pop_req_i = 5'b00001;
      tick();
    end
    idle();

    // Underflow on port 4 with a simultaneous push.
    valid_i   = 5'b10000;
    pop_req_i = 5'b10000;
    data_i[4*DW +: DW] = 32'h55;
    tick();
    idle();
    chk("udf_flag", 32'(underflow_o[4]), 32'h1);
    chk("udf_occ1", occ(4), 32'd1);
    chk("udf_data", dat(4), 32'h55);
    pop_req_i = 5'b10000;
    tick();
    idle();

    // Port 1 streaming across pointer wrap with occupancy held at 1.
    valid_i = 5'b00010;
    data_i[1*DW +: DW] = 32'h0;
    tick();
    for (int i = 1; i <= 10; i++) begin
      valid_i   = 5'b00010;
      pop_req_i = 5'b00010;
      data_i[1*DW +: DW] = 32'(i);
      tick();
      chk("wrap_occ", occ(1), 32'd1);
      chk("wrap_data", dat(1), 32'(i));
    end
    idle();
    chk("wrap_noflags", {30'd0, overflow_o[1], underflow_o[1]}, 32'h0);
    pop_req_i = 5'b00010;
    tick();
    idle();

    // Independence and mid-operation reset.
    valid_i = 5'b01001;
    data_i[0*DW +: DW] = 32'h30;
    data_i[3*DW +: DW] = 32'h33;
    tick();
    tick();
    idle();
    chk("indep_valid", 32'(valid_o), 32'h09);
    chk("indep_occ3", occ(3), 32'd2);
    rst       = 1'b1;
    valid_i   = '1;
    pop_req_i = '1;
    tick();
    rst = 1'b0;
    idle();
    chk("midrst_occ", 32'(occupancy_o), 32'h0);
    chk("midrst_valid", 32'(valid_o), 32'h0);
    chk("midrst_flags", {27'd0, overflow_o | underflow_o}, 32'h0);
    chk("midrst_drop", 32'(drop_cnt_o[15:0]), 32'h0);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
